ksa_swap: RTL and testbench

//  RC4 key-scheduling stage. Runs after the S-RAM has been filled with s[i]=i and

---
 rtl/ksa_swap_if.sv | 46 ++++
 rtl/ksa_swap.sv | 223 ++++++++++++++++++++++
 tb/tb_ksa_swap.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ksa_swap_if.sv
// ---------------------------------------------------------------------------
// ksa_swap_if
// Bundles the signals between the RC4 key-scheduling block, the master
// sequencer that starts it, and the S-RAM it scrambles.
//   start_ksa  : start request from the master (one-cycle pulse or level)
//   secret_key : KEY_W-bit key, byte 0 in the top bits
//   s_q        : S-RAM read data
//   s_address  : S-RAM address
//   s_data     : S-RAM write data
//   s_wren     : S-RAM write enable
//   ksa_finish : scheduling complete, sticky until reset
// Modports:
//   slave  - the key-scheduling block itself
//   master - the environment (master FSM plus S-RAM)
// ---------------------------------------------------------------------------
interface ksa_swap_if #(
  parameter int KEY_W = 24
);
  logic             start_ksa;
  logic [KEY_W-1:0] secret_key;
  logic [7:0]       s_q;
  logic [7:0]       s_address;
  logic [7:0]       s_data;
  logic             s_wren;
  logic             ksa_finish;

  modport slave (
    input  start_ksa,
    input  secret_key,
    input  s_q,
    output s_address,
    output s_data,
    output s_wren,
    output ksa_finish
  );

  modport master (
    output start_ksa,
    output secret_key,
    output s_q,
    input  s_address,
    input  s_data,
    input  s_wren,
    input  ksa_finish
  );
endinterface

// File: rtl/ksa_swap.sv
// ---------------------------------------------------------------------------
// ksa_swap
// RC4 key-scheduling stage. Runs once the S-RAM holds s[i]=i and scrambles
// the 256-byte array in place:
//   for i = 0..255 { j = j + s[i] + key[i mod KEY_BYTES]; swap s[i], s[j] }
// with all arithmetic modulo 256. Afterwards ksa_finish goes high and stays
// high until reset, handing the RAM to the next stage.
// Ports:
//   clk    in  system clock, all logic on the rising edge
//   reset  in  synchronous active-high reset
//   bus    slave side of ksa_swap_if (start, key, S-RAM port, finish flag)
// All S-RAM outputs and ksa_finish come straight from registers.
// The S-RAM returns read data two edges after the address register changes,
// which is why each read has a SET / WAIT / GET triplet of states.
// ---------------------------------------------------------------------------
module ksa_swap #(
  parameter int KEY_W     = 24,
  parameter int KEY_BYTES = 3
) (
  input  logic      clk,
  input  logic      reset,
  ksa_swap_if.slave bus
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SET_I  = 4'd1,
    ST_WAIT_I = 4'd2,
    ST_GET_I  = 4'd3,
    ST_SUM_J  = 4'd4,
    ST_SET_J  = 4'd5,
    ST_WAIT_J = 4'd6,
    ST_GET_J  = 4'd7,
    ST_WR_I   = 4'd8,
    ST_WR_J   = 4'd9,
    ST_NEXT   = 4'd10,
    ST_DONE   = 4'd11
  } state_t;

  // Key byte idx; byte 0 occupies the most significant bits of the key.
  function automatic logic [7:0] key_byte(
    input logic [KEY_W-1:0]  key,
    input logic [KIDX_W-1:0] idx
  );
    logic [7:0] result;
    result = 8'd0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (idx == KIDX_W'(b)) begin
        result = key[KEY_W-1-8*b -: 8];
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  state_t            r_state;
  logic [7:0]        r_i;
  logic [7:0]        r_j;
  logic [KIDX_W-1:0] r_kidx;    // tracks i mod KEY_BYTES without a divider
  logic [7:0]        r_si;
  logic [7:0]        r_sj;
  logic [7:0]        r_addr;
  logic [7:0]        r_data;
  logic              r_wren;
  logic              r_finish;

  state_t            w_state_nxt;
  logic [7:0]        w_i_nxt;
  logic [7:0]        w_j_nxt;
  logic [KIDX_W-1:0] w_kidx_nxt;
  logic [7:0]        w_si_nxt;
  logic [7:0]        w_sj_nxt;
  logic [7:0]        w_addr_nxt;
  logic [7:0]        w_data_nxt;
  logic              w_wren_nxt;
  logic              w_finish_nxt;
  logic [7:0]        w_key_byte;
  logic [KIDX_W-1:0] w_kidx_inc;

  assign w_key_byte = key_byte(bus.secret_key, r_kidx);
  assign w_kidx_inc = (r_kidx == KIDX_W'(KEY_BYTES - 1)) ? {KIDX_W{1'b0}}
                                                         : r_kidx + KIDX_W'(1);

  // Next-state and next-register-value logic for the scheduling sequence.
  always_comb begin
    w_state_nxt  = r_state;
    w_i_nxt      = r_i;
    w_j_nxt      = r_j;
    w_kidx_nxt   = r_kidx;
    w_si_nxt     = r_si;
    w_sj_nxt     = r_sj;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_wren_nxt   = r_wren;
    w_finish_nxt = r_finish;

    case (r_state)
      ST_IDLE: begin
        w_wren_nxt = 1'b0;
        if (bus.start_ksa) begin
          w_state_nxt = ST_SET_I;
          w_i_nxt     = 8'd0;
          w_j_nxt     = 8'd0;
          w_kidx_nxt  = {KIDX_W{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_SET_I: begin
        w_addr_nxt  = r_i;
        w_wren_nxt  = 1'b0;
        w_state_nxt = ST_WAIT_I;
      end

      ST_WAIT_I: begin
        w_state_nxt = ST_GET_I;
      end

      ST_GET_I: begin
        w_si_nxt    = bus.s_q;
        w_state_nxt = ST_SUM_J;
      end

      ST_SUM_J: begin
        // 8-bit sum wraps modulo 256 by construction.
        w_j_nxt     = r_j + r_si + w_key_byte;
        w_state_nxt = ST_SET_J;
      end

      ST_SET_J: begin
        w_addr_nxt  = r_j;
        w_state_nxt = ST_WAIT_J;
      end

      ST_WAIT_J: begin
        w_state_nxt = ST_GET_J;
      end

      ST_GET_J: begin
        w_sj_nxt    = bus.s_q;
        w_state_nxt = ST_WR_I;
      end

      ST_WR_I: begin
        w_addr_nxt  = r_i;
        w_data_nxt  = r_sj;
        w_wren_nxt  = 1'b1;
        w_state_nxt = ST_WR_J;
      end

      ST_WR_J: begin
        // When i == j this second write lands on the same address with the
        // original s[i], so the byte ends up unchanged.
        w_addr_nxt  = r_j;
        w_data_nxt  = r_si;
        w_wren_nxt  = 1'b1;
        w_state_nxt = ST_NEXT;
      end

      ST_NEXT: begin
        w_wren_nxt = 1'b0;
        if (r_i == 8'd255) begin
          // Flag goes up on the same edge that enters DONE so it appears
          // exactly 256 x 10 edges after the start edge.
          w_finish_nxt = 1'b1;
          w_state_nxt  = ST_DONE;
        end else begin
          w_i_nxt     = r_i + 8'd1;
          w_kidx_nxt  = w_kidx_inc;
          w_state_nxt = ST_SET_I;
        end
      end

      ST_DONE: begin
        w_wren_nxt   = 1'b0;
        w_finish_nxt = 1'b1;
        w_state_nxt  = ST_DONE;
      end

      default: begin
        w_wren_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_i      <= 8'd0;
      r_j      <= 8'd0;
      r_kidx   <= {KIDX_W{1'b0}};
      r_si     <= 8'd0;
      r_sj     <= 8'd0;
      r_addr   <= 8'd0;
      r_data   <= 8'd0;
      r_wren   <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_i      <= w_i_nxt;
      r_j      <= w_j_nxt;
      r_kidx   <= w_kidx_nxt;
      r_si     <= w_si_nxt;
      r_sj     <= w_sj_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_wren   <= w_wren_nxt;
      r_finish <= w_finish_nxt;
    end
  end

  assign bus.s_address  = r_addr;
  assign bus.s_data     = r_data;
  assign bus.s_wren     = r_wren;
  assign bus.ksa_finish = r_finish;

endmodule

// File: tb/tb_ksa_swap.sv
// ---------------------------------------------------------------------------
// tb_ksa_swap
// Drives ksa_swap against a small S-RAM model (registered read, two edges of
// read latency from the DUT's address register) and checks the result
// against a plain RC4 key-schedule computed inside the bench.
// ---------------------------------------------------------------------------
module tb_ksa_swap;

  logic clk = 1'b0;
  logic reset;
  logic ram_init;

  always #5 clk = ~clk;

  ksa_swap_if #(.KEY_W(24)) bus ();

  ksa_swap #(.KEY_W(24), .KEY_BYTES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // S-RAM: write on wren, registered read of the current address.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus.s_wren) begin
      mem[bus.s_address] <= bus.s_data;
    end
    bus.s_q <= mem[bus.s_address];
  end

  // Edge counter and bus monitor (sampled on the falling edge).
  int cyc = 0;
  int fin_cyc = -1;
  int start_cyc = 0;
  int wa[$];
  int wd[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.s_wren === 1'b1) begin
      wa.push_back(int'(bus.s_address));
      wd.push_back(int'(bus.s_data));
    end
    if (bus.ksa_finish === 1'b1 && fin_cyc < 0) fin_cyc = cyc;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference RC4 key schedule plus the write trace it implies.
  int ref_s[256];
  int exp_wa[$];
  int exp_wd[$];
  task automatic model_ksa(input logic [23:0] key);
    int s[256];
    int kb[3];
    int j;
    int t;
    kb[0] = int'(key[23:16]);
    kb[1] = int'(key[15:8]);
    kb[2] = int'(key[7:0]);
    for (int i = 0; i < 256; i++) s[i] = i;
    exp_wa.delete();
    exp_wd.delete();
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + s[i] + kb[i % 3]) % 256;
      exp_wa.push_back(i); exp_wd.push_back(s[j]);
      exp_wa.push_back(j); exp_wd.push_back(s[i]);
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int i = 0; i < 256; i++) ref_s[i] = s[i];
  endtask

  // Early-write vectors: key, iteration, then the two expected (addr,data).
  typedef struct {
    logic [23:0] key;
    int          iter;
    int          a0, d0, a1, d1;
  } vec_t;
  vec_t vec[5];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.start_ksa = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_run(input logic [23:0] key, input bit hold);
    @(negedge clk); ram_init = 1'b1;
    @(negedge clk); ram_init = 1'b0;
    wa.delete();
    wd.delete();
    fin_cyc = -1;
    bus.secret_key = key;
    bus.start_ksa = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    if (!hold) bus.start_ksa = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    for (int k = 0; k < 3000 && fin_cyc < 0; k++) @(negedge clk);
    check({tag, " finish_seen"}, (fin_cyc >= 0), 1);
  endtask

  task automatic compare_run(input string tag, input logic [23:0] key);
    int bad;
    model_ksa(key);
    check({tag, " finish_latency"}, fin_cyc - start_cyc, 2560);
    check({tag, " write_count"}, wa.size(), 512);
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      if (k >= wa.size()) bad++;
      else if (wa[k] != exp_wa[k] || wd[k] != exp_wd[k]) bad++;
    end
    check({tag, " write_trace_errs"}, bad, 0);
    bad = 0;
    for (int k = 0; k < 256; k++) if (int'(mem[k]) != ref_s[k]) bad++;
    check({tag, " sbox_errs"}, bad, 0);
    for (int v = 0; v < 5; v++) begin
      if (vec[v].key == key && wa.size() >= 2 * vec[v].iter + 2) begin
        check($sformatf("%s it%0d wr0_addr", tag, vec[v].iter), wa[2*vec[v].iter],   vec[v].a0);
        check($sformatf("%s it%0d wr0_data", tag, vec[v].iter), wd[2*vec[v].iter],   vec[v].d0);
        check($sformatf("%s it%0d wr1_addr", tag, vec[v].iter), wa[2*vec[v].iter+1], vec[v].a1);
        check($sformatf("%s it%0d wr1_data", tag, vec[v].iter), wd[2*vec[v].iter+1], vec[v].d1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] keys[6];
    logic [23:0] k5;

    vec[0] = '{24'h000000, 0, 0, 0, 0, 0};
    vec[1] = '{24'h000000, 1, 1, 1, 1, 1};
    vec[2] = '{24'h000000, 2, 2, 3, 3, 2};
    vec[3] = '{24'h010203, 0, 0, 1, 1, 0};
    vec[4] = '{24'h010203, 1, 1, 3, 3, 0};

    reset = 1'b1;
    ram_init = 1'b0;
    bus.start_ksa = 1'b0;
    bus.secret_key = 24'h000000;
    do_reset();
    @(negedge clk);
    check("reset s_address", bus.s_address, 0);
    check("reset s_data", bus.s_data, 0);
    check("reset s_wren", bus.s_wren, 0);
    check("reset ksa_finish", bus.ksa_finish, 0);

    // Full runs: fixed keys plus randomized ones.
    keys[0] = 24'h000000;
    keys[1] = 24'h010203;
    keys[2] = 24'hFFFFFF;
    keys[3] = 24'h1A2B3C;
    keys[4] = 24'($urandom());
    keys[5] = 24'($urandom());
    for (int r = 0; r < 6; r++) begin
      do_reset();
      start_run(keys[r], 1'b0);
      wait_finish($sformatf("run%0d", r));
      compare_run($sformatf("run%0d", r), keys[r]);
    end

    // Reset during WR_I of iteration 100 (state entered 1007 edges after start).
    do_reset();
    start_run(24'h1A2B3C, 1'b0);
    for (int k = 0; k < 1100 && cyc < start_cyc + 1007; k++) @(negedge clk);
    check("midrst position", cyc - start_cyc, 1007);
    check("midrst writes_before", wa.size(), 200);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst s_wren", bus.s_wren, 0);
    check("midrst ksa_finish", bus.ksa_finish, 0);
    check("midrst s_address", bus.s_address, 0);
    repeat (20) @(negedge clk);
    check("midrst writes_after", wa.size(), 200);
    start_run(24'h1A2B3C, 1'b0);
    wait_finish("restart");
    compare_run("restart", 24'h1A2B3C);

    // start_ksa held through the run and pulsed again in DONE.
    k5 = 24'($urandom());
    do_reset();
    start_run(k5, 1'b1);
    wait_finish("hold");
    compare_run("hold", k5);
    repeat (30) @(negedge clk);
    bus.start_ksa = 1'b0;
    repeat (3) @(negedge clk);
    bus.start_ksa = 1'b1;
    @(negedge clk);
    bus.start_ksa = 1'b0;
    repeat (30) @(negedge clk);
    check("hold ksa_finish_sticky", bus.ksa_finish, 1);
    check("hold no_extra_writes", wa.size(), 512);
    check("hold s_wren_done", bus.s_wren, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
